// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared state type and ratio limits for the divider scheduler
package div_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Smallest divide ratio that still produces a meaningful square wave
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/div_sched_arb.sv
// rtl/div_sched_arb.sv - two-requester grant logic; round-robin when DIV_SCHED_RR_EN is defined
module div_sched_arb (
`ifdef DIV_SCHED_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);

`ifdef DIV_SCHED_RR_EN
    // ptr names the requester with highest priority; the loser of the last grant
    logic ptr;

    // Hand priority to the other requester after every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end

    // One-hot grant, rotated by ptr, only while the owner allows acceptance
    always_comb begin
        grant = 2'b00;
        if (adv) begin
            if (ptr) begin
                if (req[1])      grant = 2'b10;
                else if (req[0]) grant = 2'b01;
            end else begin
                if (req[0])      grant = 2'b01;
                else if (req[1]) grant = 2'b10;
            end
        end
    end
`else
    // Fixed priority: requester 0 always wins a collision
    always_comb begin
        grant = 2'b00;
        if (adv) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/div_sched_ctrl.sv
// rtl/div_sched_ctrl.sv - programmable clock divider with arbitrated ratio updates (option: DIV_SCHED_RR_EN)
module div_sched_ctrl
    import div_sched_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           req_valid,
    input  logic [2*CNT_W-1:0]   req_div,
    output logic [1:0]           req_ready,
    output logic [CNT_W-1:0]     cur_div,
    output logic [CNT_W-1:0]     cnt,
    output logic                 tick,
    output logic                 div_out,
    output logic                 pend,
    output logic                 err
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] nxt_div;
    logic [CNT_W-1:0] nxt_pdiv;
    logic [CNT_W-1:0] acc_div;
    logic [CNT_W:0]   half;
    logic [1:0]       grant;
    logic             arb_en;
    logic             acc;
    logic             legal;
    logic             take;
    logic             nxt_do;

    // Requests are only taken when not already holding a pending ratio
    assign arb_en = !rst && (state != ST_PEND);

    div_sched_arb u_arb (
`ifdef DIV_SCHED_RR_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .req   (req_valid),
        .adv   (arb_en),
        .grant (grant)
    );

    assign req_ready = grant;
    assign acc       = |grant;
    assign acc_div   = grant[1] ? req_div[CNT_W +: CNT_W] : req_div[0 +: CNT_W];
    assign legal     = acc_div >= CNT_W'(MIN_DIV);
    assign take      = acc && legal;
    assign tick      = (state != ST_IDLE) && (cnt == cur_div - ONE);
    assign pend      = (state == ST_PEND);

    // Next state, counter and ratio; div_out is derived from these so the flop shows the new cycle's phase
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_div   = cur_div;
        nxt_pdiv  = pend_div;
        case (state)
            ST_IDLE: begin
                nxt_cnt = '0;
                if (take) nxt_div = acc_div;
                if (en)   nxt_state = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                    if (take) nxt_div = acc_div;
                end else begin
                    nxt_cnt = tick ? '0 : cnt + ONE;
                    if (take) begin
                        if (tick) begin
                            nxt_div = acc_div;
                        end else begin
                            nxt_pdiv  = acc_div;
                            nxt_state = ST_PEND;
                        end
                    end
                end
            end
            ST_PEND: begin
                if (!en) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                    nxt_div   = pend_div;
                end else if (tick) begin
                    nxt_state = ST_RUN;
                    nxt_cnt   = '0;
                    nxt_div   = pend_div;
                end else begin
                    nxt_cnt = cnt + ONE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
        half   = ({1'b0, nxt_div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
        nxt_do = (nxt_state != ST_IDLE) && ({1'b0, nxt_cnt} < half);
    end

    // Scheduler state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_div  <= CNT_W'(DIV_INIT);
            pend_div <= CNT_W'(DIV_INIT);
            cnt      <= '0;
            div_out  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= nxt_state;
            cur_div  <= nxt_div;
            pend_div <= nxt_pdiv;
            cnt      <= nxt_cnt;
            div_out  <= nxt_do;
            err      <= acc && !legal;
        end
    end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// tb/tb_div_sched_ctrl.sv - scoreboard bench for div_sched_ctrl
module tb_div_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  req_valid;
    logic [15:0] req_div;
    logic [1:0]  req_ready;
    logic [7:0]  cur_div;
    logic [7:0]  cnt;
    logic        tick;
    logic        div_out;
    logic        pend;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;
    bit exp_err  = 1'b0;

    typedef struct {
        logic [1:0] rdy;
        bit         illegal;
    } acc_t;

    acc_t acc_q[$];

    always #5 clk = ~clk;

    div_sched_ctrl #(.CNT_W(8), .DIV_INIT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .cur_div   (cur_div),
        .cnt       (cnt),
        .tick      (tick),
        .div_out   (div_out),
        .pend      (pend),
        .err       (err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Check one cycle at the negedge, then move to just after the next posedge
    task automatic cyc(input string tag, input int e_cnt, input int e_tick,
                       input int e_do, input int e_div, input int e_pend);
        @(negedge clk);
        chk({tag, ".cnt"},     int'(cnt),     e_cnt);
        chk({tag, ".tick"},    int'(tick),    e_tick);
        chk({tag, ".div_out"}, int'(div_out), e_do);
        chk({tag, ".cur_div"}, int'(cur_div), e_div);
        chk({tag, ".pend"},    int'(pend),    e_pend);
        @(posedge clk);
        #1;
    endtask

    // Drive a request and record the handshake the scoreboard should see
    task automatic req(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] exp_rdy, input bit illegal);
        acc_t e;
        req_valid = v;
        req_div   = {d1, d0};
        if (exp_rdy != 2'b00) begin
            e.rdy     = exp_rdy;
            e.illegal = illegal;
            acc_q.push_back(e);
        end
    endtask

    task automatic clr();
        req_valid = 2'b00;
        req_div   = 16'h0000;
    endtask

    // Monitor: err follows the previous accept; every handshake pops one expectation
    always @(negedge clk) begin
        acc_t e;
        if (mon_on) begin
            chk("err", int'(err), int'(exp_err));
            exp_err = 1'b0;
            if (req_ready != 2'b00) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_ready", int'(req_ready), 0);
                end else begin
                    e = acc_q.pop_front();
                    chk("req_ready", int'(req_ready), int'(e.rdy));
                    exp_err = e.illegal;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] coll_rdy [3];
    int         coll_cur [3];

    initial begin
        // Reset overrides en and a pending request
        rst = 1'b1; en = 1'b1;
        req_valid = 2'b01; req_div = {8'd0, 8'd7};
        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        chk("rst.req_ready", int'(req_ready), 0);
        chk("rst.err", int'(err), 0);
        cyc("rst", 0, 0, 0, 3, 0);

        // Default ratio 3: 1,1,0 with tick at cnt 2
        rst = 1'b0; en = 1'b1; clr();
        cyc("idle", 0, 0, 0, 3, 0);
        for (int p = 0; p < 2; p++) begin
            cyc("r3", 0, 0, 1, 3, 0);
            cyc("r3", 1, 0, 1, 3, 0);
            cyc("r3", 2, 1, 0, 3, 0);
        end

        // Mid-period write of 4 goes pending, applied at the wrap
        req(2'b01, 8'd4, 8'd0, 2'b01, 1'b0);
        cyc("p4_req", 0, 0, 1, 3, 0);
        clr();
        cyc("p4", 1, 0, 1, 3, 1);
        cyc("p4", 2, 1, 0, 3, 1);
        cyc("r4", 0, 0, 1, 4, 0);
        cyc("r4", 1, 0, 1, 4, 0);
        cyc("r4", 2, 0, 0, 4, 0);
        cyc("r4", 3, 1, 0, 4, 0);

        // Illegal ratio 1: consumed, err pulse, nothing else changes
        req(2'b10, 8'd0, 8'd1, 2'b10, 1'b1);
        cyc("ill", 0, 0, 1, 4, 0);
        clr();
        cyc("ill", 1, 0, 1, 4, 0);
        cyc("ill", 2, 0, 0, 4, 0);
        cyc("ill", 3, 1, 0, 4, 0);

        // en dropped while holding 6 applies it on the way to IDLE
        req(2'b01, 8'd6, 8'd0, 2'b01, 1'b0);
        cyc("p6_req", 0, 0, 1, 4, 0);
        clr();
        en = 1'b0;
        cyc("p6", 1, 0, 1, 4, 1);
        en = 1'b1;
        cyc("idle6", 0, 0, 0, 6, 0);
        for (int i = 0; i < 6; i++) cyc("r6", i, (i == 5), (i < 3), 6, 0);

        // Reset while pending 9 discards it
        req(2'b10, 8'd0, 8'd9, 2'b10, 1'b0);
        cyc("p9_req", 0, 0, 1, 6, 0);
        clr();
        rst = 1'b1;
        cyc("p9", 1, 0, 1, 6, 1);
        rst = 1'b0;
        chk("post_rst.req_ready", int'(req_ready), 0);
        cyc("post_rst", 0, 0, 0, 3, 0);
        cyc("r3b", 0, 0, 1, 3, 0);
        cyc("r3b", 1, 0, 1, 3, 0);
        cyc("r3b", 2, 1, 0, 3, 0);
        en = 1'b0;
        cyc("r3b_stop", 0, 0, 1, 3, 0);
        cyc("idle3", 0, 0, 0, 3, 0);

        // Collision in IDLE: req0 writes 5, req1 writes 6
`ifdef DIV_SCHED_RR_EN
        coll_rdy[0] = 2'b01; coll_rdy[1] = 2'b10; coll_rdy[2] = 2'b01;
        coll_cur[0] = 3;     coll_cur[1] = 5;     coll_cur[2] = 6;
`else
        coll_rdy[0] = 2'b01; coll_rdy[1] = 2'b01; coll_rdy[2] = 2'b01;
        coll_cur[0] = 3;     coll_cur[1] = 5;     coll_cur[2] = 5;
`endif
        for (int k = 0; k < 3; k++) begin
            req(2'b11, 8'd5, 8'd6, coll_rdy[k], 1'b0);
            cyc("coll", 0, 0, 0, coll_cur[k], 0);
        end
        clr();
        en = 1'b1;
        cyc("idle5", 0, 0, 0, 5, 0);

        // Ratio 5, then a write of 7 on the terminal cycle applies at that wrap
        for (int i = 0; i < 5; i++) begin
            if (i == 4) req(2'b01, 8'd7, 8'd0, 2'b01, 1'b0);
            cyc("r5", i, (i == 4), (i < 3), 5, 0);
        end
        clr();
        for (int i = 0; i < 7; i++) begin
            if (i == 6) req(2'b01, 8'd2, 8'd0, 2'b01, 1'b0);
            cyc("r7", i, (i == 6), (i < 4), 7, 0);
        end
        clr();

        // Minimum legal ratio 2: 1,0 with tick every other cycle
        for (int p = 0; p < 2; p++) begin
            cyc("r2", 0, 0, 1, 2, 0);
            cyc("r2", 1, 1, 0, 2, 0);
        end

        @(negedge clk);
        chk("acc_q_empty", acc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
